fpga_cam_wr_ctrl: RTL

//  Host-side initiator for the fpga_cam write port. Queues insert/delete rule requests (valid/ready),

---
 rtl/fpga_cam_pkg.sv | 35 +++
 rtl/fpga_cam_wr_ctrl_if.sv | 34 +++
 rtl/fpga_cam_req_fifo.sv | 63 ++++++
 rtl/fpga_cam_wr_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/fpga_cam_pkg.sv
// Shared types for the fpga_cam write controller: op codes, FSM states and the queued rule word.
package fpga_cam_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
    localparam int WIDTH = 36;
    localparam int KBITS = 16;

    typedef enum logic {OP_INSERT = 1'b0, OP_DELETE = 1'b1} cam_op_e;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SETTLE, S_DONE} wr_state_e;

    typedef struct packed {
        cam_op_e          op;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] patt;
        logic [WIDTH-1:0] mask;
        logic [KBITS-1:0] kbit;
    } cam_wreq_t;

    // A DELETE becomes an all-don't-care entry with kbit=0, which can never match.
    function automatic cam_wreq_t make_wreq(input logic op, input logic [AW-1:0] addr,
                                            input logic [WIDTH-1:0] patt,
                                            input logic [WIDTH-1:0] mask,
                                            input logic [KBITS-1:0] kbit);
        cam_wreq_t r;
        r.op   = op ? OP_DELETE : OP_INSERT;
        r.addr = addr;
        r.patt = op ? '0 : patt;
        r.mask = op ? '1 : mask;
        r.kbit = op ? '0 : kbit;
        return r;
    endfunction

endpackage

// File: rtl/fpga_cam_wr_ctrl_if.sv
// Control-plane request/done handshake plus the CAM write-port bus driven by the controller.
interface fpga_cam_wr_ctrl_if;
    import fpga_cam_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_patt;
    logic [WIDTH-1:0] req_mask;
    logic [KBITS-1:0] req_kbit;
    logic             done_valid;
    logic [AW-1:0]    done_addr;
    logic             done_op;
    logic             cam_wEn;
    logic [AW-1:0]    cam_wAddr;
    logic [WIDTH-1:0] cam_wPatt;
    logic [WIDTH-1:0] cam_wMask;
    logic [KBITS-1:0] cam_wKbit;
    logic             lookup_block;

    modport master (
        input  req_valid, req_op, req_addr, req_patt, req_mask, req_kbit,
        output req_ready, done_valid, done_addr, done_op,
        output cam_wEn, cam_wAddr, cam_wPatt, cam_wMask, cam_wKbit, lookup_block
    );

    modport slave (
        output req_valid, req_op, req_addr, req_patt, req_mask, req_kbit,
        input  req_ready, done_valid, done_addr, done_op,
        input  cam_wEn, cam_wAddr, cam_wPatt, cam_wMask, cam_wKbit, lookup_block
    );

endinterface

// File: rtl/fpga_cam_req_fifo.sv
// Small synchronous FIFO of CAM rule words; full is registered so ready never depends on valid.
module fpga_cam_req_fifo
    import fpga_cam_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  cam_wreq_t wdata,
    output cam_wreq_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW_F = $clog2(FIFO_DEPTH);
    localparam logic [AW_F:0] FULL_CNT = (AW_F + 1)'(FIFO_DEPTH);

    cam_wreq_t       mem [FIFO_DEPTH];
    logic [AW_F-1:0] wr_ptr;
    logic [AW_F-1:0] rd_ptr;
    logic [AW_F:0]   count;
    logic [AW_F:0]   count_nxt;
    logic            full_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = full_q;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpga_cam_wr_ctrl.sv
// Host-side write initiator for one fpga_cam write port: queues rules, sweeps each one into the
// BRAMs for WR_CYCLES, settles, then reports completion.
module fpga_cam_wr_ctrl
    import fpga_cam_pkg::*;
#(
    parameter int WR_CYCLES     = 64,
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                clk,
    input logic                rst,
    fpga_cam_wr_ctrl_if.master bus
);

    localparam int CNT_MAX = (WR_CYCLES > SETTLE_CYCLES) ? WR_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] WR_LOAD     = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    wr_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wen, wen_nxt;
    logic             blk, blk_nxt;
    logic             done_q, done_nxt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    cam_wreq_t        head;
    cam_wreq_t        cur;

    fpga_cam_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.req_valid && !fifo_full),
        .pop   (pop),
        .wdata (make_wreq(bus.req_op, bus.req_addr, bus.req_patt, bus.req_mask, bus.req_kbit)),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wen_nxt   = wen;
        blk_nxt   = blk;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    wen_nxt   = 1'b1;
                    blk_nxt   = 1'b1;
                    cnt_nxt   = WR_LOAD;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    wen_nxt = 1'b0;
                    if (SETTLE_CYCLES == 0) begin
                        blk_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt   = SETTLE_LOAD;
                        state_nxt = S_SETTLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    blk_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The held rule word doubles as the CAM write bus and the done report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            wen    <= 1'b0;
            blk    <= 1'b0;
            done_q <= 1'b0;
            cur    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wen    <= wen_nxt;
            blk    <= blk_nxt;
            done_q <= done_nxt;
            if (pop) cur <= head;
        end
    end

    assign bus.req_ready    = !fifo_full;
    assign bus.cam_wEn      = wen;
    assign bus.cam_wAddr    = cur.addr;
    assign bus.cam_wPatt    = cur.patt;
    assign bus.cam_wMask    = cur.mask;
    assign bus.cam_wKbit    = cur.kbit;
    assign bus.lookup_block = blk;
    assign bus.done_valid   = done_q;
    assign bus.done_addr    = cur.addr;
    assign bus.done_op      = cur.op;

endmodule
